// File: rtl/activation_pkg.sv
// Shared definitions for the spiking activation stage: membrane reset modes
// and the run-control state encoding.
package activation_pkg;

  localparam logic RESET_TO_ZERO  = 1'b0;
  localparam logic RESET_SUBTRACT = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/activation_lif_element.sv
// One leaky-free integrate-and-fire channel: saturating membrane integration,
// signed threshold compare, reset-to-zero or subtract-threshold, and a
// saturating spike counter.
module activation_lif_element
  import activation_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int TIMER_WIDTH = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr_i,
  input  logic                         step_en_i,
  input  logic                         mode_i,
  input  logic signed [DATA_WIDTH-1:0] thr_i,
  input  logic signed [DATA_WIDTH-1:0] current_i,
  output logic                         fire_o,
  output logic [TIMER_WIDTH-1:0]       count_o
);

  logic signed [DATA_WIDTH-1:0] v_q, v_d, v_sum;
  logic signed [DATA_WIDTH:0]   sum_wide, diff_wide;
  logic [TIMER_WIDTH-1:0]       count_q, count_d;

  // Clamp a one-bit-wider signed result back into DATA_WIDTH: overflow shows
  // up as the two top bits disagreeing, and the top bit gives the direction.
  function automatic logic signed [DATA_WIDTH-1:0] sat(input logic signed [DATA_WIDTH:0] x);
    if (x[DATA_WIDTH] != x[DATA_WIDTH-1]) begin
      if (x[DATA_WIDTH]) return {1'b1, {(DATA_WIDTH-1){1'b0}}};
      else               return {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end
    return x[DATA_WIDTH-1:0];
  endfunction

  // Integrate, compare and select the next membrane / counter value.
  always_comb begin
    // NOTE: every variable gets a default at the top so no path leaves it
    // unassigned, which would otherwise infer a latch.
    sum_wide  = {v_q[DATA_WIDTH-1], v_q} + {current_i[DATA_WIDTH-1], current_i};
    v_sum     = sat(sum_wide);
    diff_wide = {v_sum[DATA_WIDTH-1], v_sum} - {thr_i[DATA_WIDTH-1], thr_i};
    fire_o    = (v_sum >= thr_i);
    v_d       = v_q;
    count_d   = count_q;
    if (clr_i) begin
      v_d     = '0;
      count_d = '0;
    end else if (step_en_i) begin
      if (fire_o) begin
        v_d = (mode_i == RESET_SUBTRACT) ? sat(diff_wide) : '0;
        if (count_q != '1) count_d = count_q + 1'b1;
      end else begin
        v_d = v_sum;
      end
    end
  end

  // Membrane and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (rst) begin
      v_q     <= '0;
      count_q <= '0;
    end else begin
      v_q     <= v_d;
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/activation_array.sv
// N-channel spiking activation stage: run-control FSM, step counter, latched
// run configuration and one activation_lif_element per channel.
module activation_array
  import activation_pkg::*;
#(
  parameter int NUM_CHANNELS  = 3,
  parameter int DATA_WIDTH    = 16,
  parameter int TIMER_WIDTH   = 5,
  parameter int NUM_TIMESTEPS = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic                                reset_mode,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0]  threshold_flat,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0]  current_flat,
  output logic                                spike_valid,
  output logic [NUM_CHANNELS-1:0]             spike_vec,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [NUM_CHANNELS*TIMER_WIDTH-1:0] spike_count_flat,
  output logic                                busy
);

  localparam int                STEP_W    = $clog2(NUM_TIMESTEPS + 1);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_TIMESTEPS - 1);

  state_e                            state_q, state_d;
  logic [STEP_W-1:0]                 step_q;
  logic [NUM_CHANNELS*DATA_WIDTH-1:0] thr_q;
  logic                              mode_q;
  logic [NUM_CHANNELS-1:0]           fire_w, spike_vec_q;
  logic                              spike_valid_q;
  logic                              clr, accept, last_step;

  assign clr       = start && (state_q == IDLE);
  assign accept    = in_valid && in_ready;
  assign last_step = (step_q == LAST_STEP);

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state: start only counts in IDLE, so a start in DONE is dropped.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (accept && last_step) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    in_ready  = (state_q == RUN);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
  end

  // Run configuration, step counter and the registered per-step spike report.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      thr_q         <= '0;
      mode_q        <= RESET_TO_ZERO;
      step_q        <= '0;
      spike_vec_q   <= '0;
      spike_valid_q <= 1'b0;
    end else begin
      spike_valid_q <= accept;
      if (clr) begin
        thr_q  <= threshold_flat;
        mode_q <= reset_mode;
        step_q <= '0;
      end else if (accept) begin
        step_q      <= step_q + 1'b1;
        spike_vec_q <= fire_w;
      end
    end
  end

  assign spike_vec   = spike_vec_q;
  assign spike_valid = spike_valid_q;

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
    activation_lif_element #(
      .DATA_WIDTH (DATA_WIDTH),
      .TIMER_WIDTH(TIMER_WIDTH)
    ) u_lif (
      .clk      (clk),
      .rst      (rst),
      .clr_i    (clr),
      .step_en_i(accept),
      .mode_i   (mode_q),
      .thr_i    (thr_q[c*DATA_WIDTH +: DATA_WIDTH]),
      .current_i(current_flat[c*DATA_WIDTH +: DATA_WIDTH]),
      .fire_o   (fire_w[c]),
      .count_o  (spike_count_flat[c*TIMER_WIDTH +: TIMER_WIDTH])
    );
  end

endmodule

// File: tb/tb_activation_array.sv
// Bench for activation_array: hand-derived vectors, gap/backpressure/reset
// sequences and randomized runs against an integer reference model. A second
// instance with NUM_TIMESTEPS=1 shares the inputs and is checked each run.
module tb_activation_array;

  localparam int NCH  = 3;
  localparam int DW   = 16;
  localparam int TW   = 3;
  localparam int NT   = 16;
  localparam int FW   = NCH * DW;
  localparam int CMAX = 2**TW - 1;
  localparam int VMAX = 2**(DW-1) - 1;
  localparam int VMIN = -(2**(DW-1));

  logic           clk = 1'b0;
  logic           rst, start, reset_mode, in_valid, out_ready;
  logic [FW-1:0]  threshold_flat, current_flat;
  logic           in_ready, spike_valid, out_valid, busy;
  logic [NCH-1:0] spike_vec;
  logic [NCH*TW-1:0] spike_count_flat;
  logic           in_ready1, spike_valid1, out_valid1, busy1;
  logic [NCH-1:0] spike_vec1;
  logic [NCH*TW-1:0] spike_count_flat1;

  always #5 clk = ~clk;

  activation_array #(.NUM_CHANNELS(NCH), .DATA_WIDTH(DW), .TIMER_WIDTH(TW), .NUM_TIMESTEPS(NT)) dut (
    .clk(clk), .rst(rst), .start(start), .reset_mode(reset_mode), .threshold_flat(threshold_flat),
    .in_valid(in_valid), .in_ready(in_ready), .current_flat(current_flat),
    .spike_valid(spike_valid), .spike_vec(spike_vec), .out_valid(out_valid), .out_ready(out_ready),
    .spike_count_flat(spike_count_flat), .busy(busy));

  activation_array #(.NUM_CHANNELS(NCH), .DATA_WIDTH(DW), .TIMER_WIDTH(TW), .NUM_TIMESTEPS(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .reset_mode(reset_mode), .threshold_flat(threshold_flat),
    .in_valid(in_valid), .in_ready(in_ready1), .current_flat(current_flat),
    .spike_valid(spike_valid1), .spike_vec(spike_vec1), .out_valid(out_valid1), .out_ready(out_ready),
    .spike_count_flat(spike_count_flat1), .busy(busy1));

  typedef struct packed {
    logic                   mode;
    logic [NCH-1:0][DW-1:0] thr;
    logic [NCH-1:0][DW-1:0] cur;
    logic [NCH-1:0][TW-1:0] expc;
  } vec_t;

  vec_t  vecs[5];
  string vname[5] = '{"T1_zero", "T2_sub", "T3_sat", "T4_max_zero", "T4_max_sub"};

  int             n_cmp = 0;
  int             n_err = 0;
  bit             m_mode;
  int             m_thr[NCH];
  int             m_cur[NT][NCH];
  logic [NCH-1:0] m_spk[NT];
  int             m_cnt[NCH];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic int clamp(input int x);
    if (x > VMAX) return VMAX;
    if (x < VMIN) return VMIN;
    return x;
  endfunction

  // Reference: integer membranes following the firing rules step by step.
  task automatic model_run();
    int v[NCH];
    int s_sum;
    for (int c = 0; c < NCH; c++) begin
      v[c] = 0;
      m_cnt[c] = 0;
    end
    for (int s = 0; s < NT; s++) begin
      for (int c = 0; c < NCH; c++) begin
        s_sum = clamp(v[c] + m_cur[s][c]);
        m_spk[s][c] = (s_sum >= m_thr[c]);
        if (m_spk[s][c]) begin
          v[c] = m_mode ? clamp(s_sum - m_thr[c]) : 0;
          if (m_cnt[c] < CMAX) m_cnt[c]++;
        end else begin
          v[c] = s_sum;
        end
      end
    end
  endtask

  function automatic logic [FW-1:0] pack_thr();
    logic [FW-1:0] r;
    for (int c = 0; c < NCH; c++) r[c*DW +: DW] = DW'(m_thr[c]);
    return r;
  endfunction

  function automatic logic [FW-1:0] pack_cur(input int s);
    logic [FW-1:0] r;
    for (int c = 0; c < NCH; c++) r[c*DW +: DW] = DW'(m_cur[s][c]);
    return r;
  endfunction

  function automatic logic [NCH*TW-1:0] pack_cnt();
    logic [NCH*TW-1:0] r;
    for (int c = 0; c < NCH; c++) r[c*TW +: TW] = TW'(m_cnt[c]);
    return r;
  endfunction

  task automatic load_vec(input int i);
    m_mode = vecs[i].mode;
    for (int c = 0; c < NCH; c++) begin
      m_thr[c] = int'($signed(vecs[i].thr[c]));
      for (int s = 0; s < NT; s++) m_cur[s][c] = int'($signed(vecs[i].cur[c]));
    end
  endtask

  task automatic load_random(input bit wide);
    m_mode = 1'($urandom_range(1));
    for (int c = 0; c < NCH; c++) begin
      m_thr[c] = wide ? int'($signed(DW'($urandom()))) : int'($urandom_range(90)) - 10;
      for (int s = 0; s < NT; s++)
        m_cur[s][c] = wide ? int'($signed(DW'($urandom()))) : int'($urandom_range(60)) - 20;
    end
  endtask

  task automatic start_run();
    @(negedge clk);
    start = 1'b1;
    reset_mode = m_mode;
    threshold_flat = pack_thr();
    @(posedge clk); #1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic apply_step(input string name, input int s);
    logic [NCH*TW-1:0] e1;
    in_valid = 1'b1;
    current_flat = pack_cur(s);
    @(posedge clk); #1;
    check({name, " spike_valid"}, 64'(spike_valid), 64'(1'b1));
    check({name, " spike_vec"}, 64'(spike_vec), 64'(m_spk[s]));
    if (s == 0) begin
      for (int c = 0; c < NCH; c++) e1[c*TW +: TW] = TW'(m_spk[0][c]);
      check({name, " ts1 out_valid"}, 64'(out_valid1), 64'(1'b1));
      check({name, " ts1 in_ready"}, 64'(in_ready1), 64'(1'b0));
      check({name, " ts1 busy"}, 64'(busy1), 64'(1'b1));
      check({name, " ts1 spike"}, 64'({spike_valid1, spike_vec1}), 64'({1'b1, m_spk[0]}));
      check({name, " ts1 counts"}, 64'(spike_count_flat1), 64'(e1));
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Full run: start, NT steps (optionally with idle gaps and stray starts),
  // out_ready held low for 'hold' cycles, then handshake together with start.
  task automatic run_case(input string name, input bit gaps, input bit poke,
                          input int hold, input logic [NCH*TW-1:0] expc);
    model_run();
    @(negedge clk);
    start = 1'b1;
    reset_mode = m_mode;
    threshold_flat = pack_thr();
    @(posedge clk); #1;
    check({name, " busy"}, 64'({busy, in_ready, out_valid}), 64'(3'b110));
    check({name, " cleared"}, 64'(spike_count_flat), 64'(0));
    @(negedge clk);
    start = 1'b0;
    for (int s = 0; s < NT; s++) begin
      if (gaps) begin
        for (int g = 0; g < 2; g++) begin
          in_valid = 1'b0;
          current_flat = FW'({$urandom(), $urandom()});
          start = poke && (g == 0);
          @(posedge clk); #1;
          check({name, " gap spike_valid"}, 64'(spike_valid), 64'(1'b0));
          check({name, " gap in_ready"}, 64'(in_ready), 64'(1'b1));
          @(negedge clk);
          start = 1'b0;
        end
      end
      apply_step(name, s);
    end
    check({name, " done"}, 64'({busy, in_ready, out_valid}), 64'(3'b101));
    check({name, " counts"}, 64'(spike_count_flat), 64'(expc));
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      @(posedge clk); #1;
      check({name, " hold out_valid"}, 64'(out_valid), 64'(1'b1));
      check({name, " hold counts"}, 64'(spike_count_flat), 64'(expc));
      @(negedge clk);
    end
    out_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    check({name, " to idle"}, 64'({busy, out_valid}), 64'(2'b00));
    check({name, " idle counts"}, 64'(spike_count_flat), 64'(expc));
    @(negedge clk);
    out_ready = 1'b0;
    start = 1'b0;
    @(posedge clk); #1;
    check({name, " start ignored"}, 64'(busy), 64'(1'b0));
  endtask

  initial begin
    vecs[0] = '{1'b0, {16'hFFFB, 16'd10, 16'd10}, {16'd0, 16'd4, 16'd4}, {3'd7, 3'd5, 3'd5}};
    vecs[1] = '{1'b1, {16'd3, 16'd10, 16'd10}, {16'd1, 16'hFFFC, 16'd4}, {3'd5, 3'd0, 3'd6}};
    vecs[2] = '{1'b0, {16'd1, 16'd1, 16'd1}, {16'd0, 16'd1, 16'd100}, {3'd0, 3'd7, 3'd7}};
    vecs[3] = '{1'b0, {16'h7FFF, 16'h7FFF, 16'h7FFF}, {16'd1, 16'h8000, 16'h7FFF}, {3'd0, 3'd0, 3'd7}};
    vecs[4] = '{1'b1, {16'h8000, 16'h4000, 16'h7FFF}, {16'h7FFF, 16'h7FFF, 16'h7FFF}, {3'd7, 3'd7, 3'd7}};

    rst = 1'b1; start = 1'b0; reset_mode = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    threshold_flat = '0; current_flat = '0;
    #12;
    check("reset ctrl", 64'({busy, in_ready, out_valid, spike_valid}), 64'(4'b0000));
    check("reset data", 64'({spike_vec, spike_count_flat}), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      load_vec(i);
      run_case(vname[i], 1'b0, 1'b0, 1, vecs[i].expc);
    end

    load_vec(0);
    run_case("T5_gaps", 1'b1, 1'b1, 5, vecs[0].expc);

    // Abort on the 7th step: reset lands while that step is being offered.
    load_vec(0);
    model_run();
    start_run();
    for (int s = 0; s < 6; s++) apply_step("T6_pre", s);
    in_valid = 1'b1;
    current_flat = pack_cur(6);
    rst = 1'b1;
    #1;
    check("T6 abort ctrl", 64'({busy, in_ready, out_valid, spike_valid}), 64'(4'b0000));
    check("T6 abort data", 64'({spike_vec, spike_count_flat}), 64'(0));
    @(posedge clk); #1;
    check("T6 held", 64'({busy, out_valid, spike_valid}), 64'(3'b000));
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    run_case("T6_clean", 1'b0, 1'b0, 0, vecs[0].expc);

    for (int r = 0; r < 8; r++) begin
      load_random(r[0]);
      model_run();
      run_case($sformatf("rand%0d", r), r[1], r[2], r % 3, pack_cnt());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
